dmem_responder: RTL
===================

# dmem_responder

Memory-side responder that sits between the pipeline's load/store stage and the data `SRAM_wrapper`. It accepts valid/ready load/store requests with RISC-V funct3 sizing and drives the SRAM macro pins. It returns aligned, sign-/zero-extended load data, or a store acknowledge, through a 2-entry response buffer, so the core can stall its response side without losing data.

## Interface
- `ADDR_W`, default 14: SRAM word-address width; `sram_a = req_addr[ADDR_W+1:2]`.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_size`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned address or illegal size.
- `sram_ceb`  out  1  SRAM chip enable, active-low.
- `sram_web`  out  1  SRAM write enable, active-low.
- `sram_bweb`  out  32  SRAM bit write mask, active-low.
- `sram_a`  out  ADDR_W  SRAM word address.
- `sram_di`  out  32  SRAM write data.
- `sram_do`  in  32  SRAM read data, valid the cycle after the access.

## Operation
- **Acceptance.** `req_ready = (inflight + fifo_count < 2) || (rsp_valid && rsp_ready)`.
  - Invariant: `inflight + fifo_count <= 2`.
- **Legality.** A request is illegal if any of the following holds:
  - size is 011, 110 or 111;
  - H/HU with `addr[0] = 1`;
  - W with `addr[1:0] != 0`.
- **SRAM pin generation.** SRAM pins are combinational from the accepted request.
  - `sram_ceb = 0` only on a legal handshake.
  - `sram_web = ~req_write`.
  - When no access takes place: `ceb = 1`, `web = 1`, `bweb` all ones, `a = 0`, `di = 0`.
- **Store lanes.**
  - SB: `di = {4{wdata[7:0]}}`; `bweb` bits `[8*off+7:8*off]` cleared, where `off = addr[1:0]`.
  - SH: `di = {2{wdata[15:0]}}`; half-lane `addr[1]` cleared.
  - SW: `di = wdata`; `bweb = 0`.
- **In-flight tracking.**
  - On handshake, register `inflight = 1` plus the `{write, size, addr[1:0], err}` tag.
  - Next cycle, form the response from `sram_do` and the tag, then push it to the FIFO.
  - Illegal requests occupy the in-flight slot with no SRAM access; they respond with `err = 1`, `rdata = 0`.
- **Load extraction.** Select the byte/half by the offset.
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through unchanged.
- **Stores** respond with `rdata = 0`, `err = 0`.
- **Ordering.** Responses are strictly in request order; the FIFO is first-word-fall-through.
- **Address width.** Upper address bits above `ADDR_W+1` are ignored, so addresses alias modulo 2^(ADDR_W+2).

## Timing
- **Latency.** Accept at cycle T → `rsp_valid` at T+2 when the FIFO is empty and `rsp_ready` is held.
- **Throughput.** One request per cycle while `rsp_ready = 1`.
- **Full buffer.** With `rsp_ready = 0`, at most two requests are accepted; `req_ready` then drops until a pop.
- **Simultaneous events.** A push and a pop in the same cycle leave `fifo_count` unchanged. A pop frees a slot for an accept in the same cycle.
- **`rsp_*` stability.** `rsp_*` stay stable while `rsp_valid && !rsp_ready`.
- **Reset values.**
  - `inflight = 0`, FIFO empty, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_err = 0`.
  - `req_ready = 0` while reset is asserted, so `sram_ceb = 1`, `web = 1`, `bweb` all ones, `a = 0`, `di = 0`.
- **Reset mid-operation.** The in-flight access and buffered responses are dropped. An SRAM write already clocked is not undone.
- **FIFO write pointer.** The pointer wraps modulo 2; overflow is impossible by the acceptance rule.

## Structure
- Package `mem_pkg` contains:
  - `size_e` enum for the funct3 encodings;
  - `rsp_t` struct `{rdata, err}`;
  - lane-mask constants.
- Sub-module `rsp_fifo`: 2-entry FIFO of `rsp_t`, with push/pop/count, the same clock and reset, and a FWFT output.
- The top level holds the request decode, SRAM pin generation, in-flight tag register and load extraction.

## Test plan
- SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → SRAM sees `a = 4`, `bweb = 0`; the load response returns 0xDEADBEEF, 2 cycles after accept.
- SB 0x13 data 0x80; LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080.
  - Check that `bweb[31:24] = 0` and all other `bweb` bits are 1.
- LH 0x01 → no SRAM access (`ceb` stays 1); `rsp_err = 1`, `rdata = 0`.
  - Repeat with `size = 011` at an aligned address; the same response is required.
- `rsp_ready` held 0 while issuing 4 loads → only 2 accepted, `req_ready = 0`.
  - Release `rsp_ready` → remaining loads are accepted; all 4 responses return in order with correct data.
- Back-to-back 8 loads with `rsp_ready = 1` → `req_ready` stays 1 and `rsp_valid` is continuous from cycle T+2.
- Assert `rst` low with one access in flight and one buffered → `rsp_valid` drops to 0 immediately.
  - After release: `req_ready = 1` and no stale response appears.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder: funct3 sizing,
// response payload, in-flight tag and store lane masks.
package mem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic       write;
        size_e      size;
        logic [1:0] off;
        logic       err;
    } tag_t;

    localparam logic [31:0] BYTE_LANE = 32'h0000_00FF;
    localparam logic [31:0] HALF_LANE = 32'h0000_FFFF;

    // Unused funct3 codes and misaligned halfword/word offsets are illegal.
    function automatic logic size_legal(input logic [2:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~off[0];
            SZ_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry first-word-fall-through response buffer; head reads as zero when empty.
module rsp_fifo
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rsp_t       push_data,
    input  logic       pop,
    output rsp_t       head,
    output logic       valid,
    output logic [1:0] count
);

    rsp_t       mem_q [2];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q ^ push;
        rptr_d  = rptr_q ^ pop;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= push_data;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign valid = (count_q != 2'd0);
    assign count = count_q;
    assign head  = valid ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder in front of the data SRAM: decodes sized requests,
// drives the macro pins, and returns extended load data through rsp_fifo.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [31:0]       sram_bweb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_di,
    input  logic [31:0]       sram_do
);

    logic       inflight_q, inflight_d;
    tag_t       tag_q, tag_d;
    logic [1:0] fifo_count;
    logic [1:0] occupancy;
    logic       pop, hs, legal, access;
    rsp_t       rsp_d, rsp_head;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // A pop in this cycle frees a slot for a same-cycle accept.
    assign pop       = rsp_valid && rsp_ready;
    assign occupancy = {1'b0, inflight_q} + fifo_count;
    assign req_ready = rst && ((occupancy < 2'd2) || pop);
    assign hs        = req_valid && req_ready;
    assign legal     = size_legal(req_size, req_addr[1:0]);
    assign access    = hs && legal;

    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_bweb = '1;
        sram_a    = '0;
        sram_di   = '0;
        if (access) begin
            sram_ceb = 1'b0;
            sram_web = ~req_write;
            sram_a   = req_addr[ADDR_W+1:2];
            if (req_write) begin
                case (req_size[1:0])
                    2'b00: begin
                        sram_di   = {4{req_wdata[7:0]}};
                        sram_bweb = ~(BYTE_LANE << {req_addr[1:0], 3'b000});
                    end
                    2'b01: begin
                        sram_di   = {2{req_wdata[15:0]}};
                        sram_bweb = ~(HALF_LANE << {req_addr[1], 4'b0000});
                    end
                    default: begin
                        sram_di   = req_wdata;
                        sram_bweb = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        inflight_d  = hs;
        tag_d       = tag_q;
        if (hs) begin
            tag_d.write = req_write;
            tag_d.size  = size_e'(req_size);
            tag_d.off   = req_addr[1:0];
            tag_d.err   = ~legal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    // Load extraction: sram_do is valid the cycle after the access.
    always_comb begin
        logic [31:0] shifted;
        shifted = sram_do >> {tag_q.off, 3'b000};
        rsp_d   = '0;
        if (tag_q.err) begin
            rsp_d.err = 1'b1;
        end else if (!tag_q.write) begin
            case (tag_q.size)
                SZ_B:    rsp_d.rdata = {{24{shifted[7]}}, shifted[7:0]};
                SZ_BU:   rsp_d.rdata = {24'h0, shifted[7:0]};
                SZ_H:    rsp_d.rdata = {{16{shifted[15]}}, shifted[15:0]};
                SZ_HU:   rsp_d.rdata = {16'h0, shifted[15:0]};
                default: rsp_d.rdata = sram_do;
            endcase
        end
    end

    rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rsp_d),
        .pop       (pop),
        .head      (rsp_head),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

    assign rsp_rdata = rsp_head.rdata;
    assign rsp_err   = rsp_head.err;

endmodule
